// File: rtl/port_change_logger.sv
// port_change_logger: logs the post-reset value of sig_in and each later change as {value, timestamp} entries in a drainable FIFO.
module port_change_logger #(
  parameter int WIDTH = 2,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH = 4
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             sig_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_value,
  output logic [TS_WIDTH-1:0]          out_time,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, next_state;
  logic [TS_WIDTH-1:0] ts, hold_time;
  logic [WIDTH-1:0] prev, hold_value;
  logic [WIDTH-1:0] mem_value [DEPTH];
  logic [TS_WIDTH-1:0] mem_time [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic change, pop, push, drop;
  always_comb begin
    next_state = RUN;
    change = (state == INIT) || (sig_in !== prev);
  end
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push = change && (count != FULL || pop);
  assign drop = change && !push;
  // when empty, show the last popped entry rather than a stale slot
  assign out_value = out_valid ? mem_value[rd_ptr] : hold_value;
  assign out_time = out_valid ? mem_time[rd_ptr] : hold_time;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      ts <= '0;
      prev <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      hold_value <= '0;
      hold_time <= '0;
    end else begin
      state <= next_state;
      ts <= ts + TS_WIDTH'(1);
      prev <= sig_in;
      if (push) begin
        mem_value[wr_ptr] <= sig_in;
        mem_time[wr_ptr] <= ts;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        hold_value <= mem_value[rd_ptr];
        hold_time <= mem_time[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      overflow <= overflow | drop;
    end
  end
endmodule

// File: tb/tb_port_change_logger.sv
// tb_port_change_logger: directed vector table plus hand sequences for init logging, overflow, wrap and reset flush.
module tb_port_change_logger;
  logic clk = 1'b0;
  logic rst, out_ready, out_valid, overflow;
  logic [1:0] sig_in, out_value;
  logic [15:0] out_time;
  logic [2:0] count;
  logic rst4, ready4, valid4, overflow4;
  logic [1:0] sig4, value4;
  logic [3:0] time4;
  logic [2:0] count4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  port_change_logger dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_time(out_time), .count(count), .overflow(overflow)
  );

  port_change_logger #(.WIDTH(2), .TS_WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4), .sig_in(sig4), .out_valid(valid4), .out_ready(ready4),
    .out_value(value4), .out_time(time4), .count(count4), .overflow(overflow4)
  );

  typedef struct {
    logic rst; logic [1:0] sig; logic rdy;
    logic valid; logic [1:0] val; logic [15:0] tm; logic [2:0] cnt; logic ovf;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic r, input logic [1:0] s, input logic rd, input logic vl,
                     input logic [1:0] val, input logic [15:0] tm, input logic [2:0] c, input logic o);
    vec_t t;
    t.rst = r; t.sig = s; t.rdy = rd; t.valid = vl; t.val = val; t.tm = tm; t.cnt = c; t.ovf = o;
    v.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sig_in = 2'b00; out_ready = 1'b0;
    rst4 = 1'b1; sig4 = 2'b00; ready4 = 1'b1;
    // init logging and a change at ts=5
    add(1, 2'b10, 1, 0, 2'b00, 0, 0, 0);
    add(0, 2'b10, 1, 1, 2'b10, 0, 1, 0);
    add(0, 2'b10, 1, 0, 2'b10, 0, 0, 0);
    add(0, 2'b10, 1, 0, 2'b10, 0, 0, 0);
    add(0, 2'b10, 1, 0, 2'b10, 0, 0, 0);
    add(0, 2'b10, 1, 0, 2'b10, 0, 0, 0);
    add(0, 2'b01, 1, 1, 2'b01, 5, 1, 0);
    add(0, 2'b01, 1, 0, 2'b01, 5, 0, 0);
    // overflow: init plus changes at ts 3,4,6,8 with the consumer stalled
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b00, 0, 1, 2'b00, 0, 1, 0);
    add(0, 2'b00, 0, 1, 2'b00, 0, 1, 0);
    add(0, 2'b00, 0, 1, 2'b00, 0, 1, 0);
    add(0, 2'b01, 0, 1, 2'b00, 0, 2, 0);
    add(0, 2'b10, 0, 1, 2'b00, 0, 3, 0);
    add(0, 2'b10, 0, 1, 2'b00, 0, 3, 0);
    add(0, 2'b11, 0, 1, 2'b00, 0, 4, 0);
    add(0, 2'b11, 0, 1, 2'b00, 0, 4, 0);
    add(0, 2'b00, 0, 1, 2'b00, 0, 4, 1);
    add(0, 2'b00, 1, 1, 2'b01, 3, 3, 1);
    add(0, 2'b00, 1, 1, 2'b10, 4, 2, 1);
    add(0, 2'b00, 1, 1, 2'b11, 6, 1, 1);
    add(0, 2'b00, 1, 0, 2'b11, 6, 0, 1);
    // full FIFO with push and pop on the same edge
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b00, 0, 1, 2'b00, 0, 1, 0);
    add(0, 2'b01, 0, 1, 2'b00, 0, 2, 0);
    add(0, 2'b10, 0, 1, 2'b00, 0, 3, 0);
    add(0, 2'b11, 0, 1, 2'b00, 0, 4, 0);
    add(0, 2'b00, 1, 1, 2'b01, 1, 4, 0);
    add(0, 2'b00, 1, 1, 2'b10, 2, 3, 0);
    add(0, 2'b00, 1, 1, 2'b11, 3, 2, 0);
    add(0, 2'b00, 1, 1, 2'b00, 4, 1, 0);
    add(0, 2'b00, 1, 0, 2'b00, 4, 0, 0);
    // reset flush with 3 entries queued and overflow set
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b01, 0, 1, 2'b01, 0, 1, 0);
    add(0, 2'b10, 0, 1, 2'b01, 0, 2, 0);
    add(0, 2'b01, 0, 1, 2'b01, 0, 3, 0);
    add(0, 2'b10, 0, 1, 2'b01, 0, 4, 0);
    add(0, 2'b01, 0, 1, 2'b01, 0, 4, 1);
    add(0, 2'b01, 1, 1, 2'b10, 1, 3, 1);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b11, 0, 1, 2'b11, 0, 1, 0);
    for (int i = 0; i < v.size(); i++) begin
      rst = v[i].rst; sig_in = v[i].sig; out_ready = v[i].rdy;
      step();
      chk($sformatf("row%0d valid", i), 32'(out_valid), 32'(v[i].valid));
      chk($sformatf("row%0d value", i), 32'(out_value), 32'(v[i].val));
      chk($sformatf("row%0d time", i), 32'(out_time), 32'(v[i].tm));
      chk($sformatf("row%0d count", i), 32'(count), 32'(v[i].cnt));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(v[i].ovf));
    end
    // steady input: a single init entry, then nothing for 20 cycles
    rst = 1'b1; sig_in = 2'b10; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("steady init valid", 32'(out_valid), 32'd1);
    chk("steady init value", 32'(out_value), 32'd2);
    chk("steady init time", 32'(out_time), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("steady idle%0d valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("steady idle%0d count", i), 32'(count), 32'd0);
    end
    // 4-bit timestamp: the 17th edge after init samples ts=1 again
    step();
    rst4 = 1'b0;
    step();
    chk("wrap init time", 32'(time4), 32'd0);
    for (int i = 0; i < 16; i++) step();
    chk("wrap idle valid", 32'(valid4), 32'd0);
    sig4 = 2'b11;
    step();
    chk("wrap valid", 32'(valid4), 32'd1);
    chk("wrap value", 32'(value4), 32'd3);
    chk("wrap time", 32'(time4), 32'd1);
    chk("wrap count", 32'(count4), 32'd1);
    chk("wrap overflow", 32'(overflow4), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
